tftp_encode_controller: RTL and testbench

Transmit-side counterpart of the TFTP decode controller. On a start pulse it serialises one TFTP ACK or DATA payload byte-by-byte: opcode, block number, then for DATA the payload bytes pulled from an upstream buffer. Its output is a valid/ready byte stream into the UDP/IP/Ethernet TX framer. It sits between the TFTP session logic and the framer.

---
 rtl/tftp_pkg.sv | 22 ++
 rtl/tftp_encode_controller.sv | 157 +++++++++++++++
 tb/tb_tftp_encode_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tftp_pkg.sv
// Shared TFTP definitions for the encode and decode controllers.
// Holds the TFTP opcode values, the encoder FSM state encoding and the
// default maximum DATA payload size (TFTP block size).
package tftp_pkg;

    localparam logic [15:0] OP_RRQ   = 16'd1;
    localparam logic [15:0] OP_WRQ   = 16'd2;
    localparam logic [15:0] OP_DATA  = 16'd3;
    localparam logic [15:0] OP_ACK   = 16'd4;
    localparam logic [15:0] OP_ERROR = 16'd5;

    localparam int MAX_DATA_DEFAULT = 512;

    typedef enum logic [2:0] {
        ENC_IDLE    = 3'd0,
        ENC_OPCODE  = 3'd1,
        ENC_BLOCKNO = 3'd2,
        ENC_PAYLOAD = 3'd3,
        ENC_DONE    = 3'd4
    } enc_state_t;

endpackage

// File: rtl/tftp_encode_controller.sv
// TFTP ACK/DATA packet serialiser.
// On start it emits opcode (2 bytes), block number (2 bytes) and, for DATA,
// up to MAX_DATA payload bytes passed through from an upstream buffer, as a
// valid/ready byte stream toward the UDP/IP/Ethernet TX framer.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               request a packet (ignored while busy or in DONE)
//   pkt_ack             1 = ACK, 0 = DATA (sampled on start)
//   block_no            TFTP block number (sampled on start)
//   data_len            DATA payload length, clamped to MAX_DATA (sampled on start)
//   pay_data/pay_valid  upstream payload byte, pay_ready = byte consumed
//   tx_data/tx_valid    output byte stream, tx_ready from framer, tx_last on final byte
//   busy                packet in progress
//   done                one-cycle pulse after the final byte is accepted
//
// state       | meaning
// ------------+-------------------------------------------------------
// ENC_IDLE    | waiting for start
// ENC_OPCODE  | sending opcode, idx selects hi (0) / lo (1) byte
// ENC_BLOCKNO | sending block number, idx selects hi (0) / lo (1) byte
// ENC_PAYLOAD | passing payload bytes through, remaining counts down
// ENC_DONE    | done pulse, back to idle next cycle
module tftp_encode_controller
    import tftp_pkg::*;
#(
    parameter int MAX_DATA = MAX_DATA_DEFAULT,
    parameter int LEN_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pkt_ack,
    input  logic [15:0]      block_no,
    input  logic [LEN_W-1:0] data_len,
    input  logic [7:0]       pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_last,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DATA);

    enc_state_t       state;
    logic             idx;
    logic             ack_r;
    logic [15:0]      blk_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       hdr_data;
    logic             hdr_valid;
    logic             hdr_last;
    logic             busy_r;
    logic             done_r;

    // Header bytes come from registers loaded one byte ahead of the transfer,
    // so tx_data/tx_last stay stable while the framer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ENC_IDLE;
            idx       <= 1'b0;
            ack_r     <= 1'b0;
            blk_r     <= '0;
            len_r     <= '0;
            remaining <= '0;
            hdr_data  <= 8'h00;
            hdr_valid <= 1'b0;
            hdr_last  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ENC_IDLE: begin
                    if (start) begin
                        ack_r     <= pkt_ack;
                        blk_r     <= block_no;
                        len_r     <= (data_len > MAX_LEN) ? MAX_LEN : data_len;
                        state     <= ENC_OPCODE;
                        idx       <= 1'b0;
                        hdr_data  <= 8'h00;
                        hdr_valid <= 1'b1;
                        hdr_last  <= 1'b0;
                        busy_r    <= 1'b1;
                    end
                end
                ENC_OPCODE: begin
                    if (tx_ready) begin
                        if (!idx) begin
                            idx      <= 1'b1;
                            hdr_data <= ack_r ? OP_ACK[7:0] : OP_DATA[7:0];
                        end else begin
                            idx      <= 1'b0;
                            state    <= ENC_BLOCKNO;
                            hdr_data <= blk_r[15:8];
                        end
                    end
                end
                ENC_BLOCKNO: begin
                    if (tx_ready) begin
                        if (!idx) begin
                            idx      <= 1'b1;
                            hdr_data <= blk_r[7:0];
                            hdr_last <= ack_r || (len_r == '0);
                        end else begin
                            idx       <= 1'b0;
                            hdr_data  <= 8'h00;
                            hdr_valid <= 1'b0;
                            hdr_last  <= 1'b0;
                            if (ack_r || (len_r == '0)) begin
                                state  <= ENC_DONE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                state     <= ENC_PAYLOAD;
                                remaining <= len_r;
                            end
                        end
                    end
                end
                ENC_PAYLOAD: begin
                    if (pay_valid && tx_ready) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state  <= ENC_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                ENC_DONE: begin
                    state <= ENC_IDLE;
                end
                default: begin
                    state <= ENC_IDLE;
                end
            endcase
        end
    end

    // Payload is a combinational pass-through so the upstream buffer sees
    // the framer's backpressure directly.
    logic in_pay;
    assign in_pay    = (state == ENC_PAYLOAD);
    assign tx_data   = in_pay ? pay_data : hdr_data;
    assign tx_valid  = in_pay ? pay_valid : hdr_valid;
    assign tx_last   = in_pay ? (remaining == LEN_W'(1)) : hdr_last;
    assign pay_ready = in_pay && tx_ready;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_tftp_encode_controller.sv
module tb_tftp_encode_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pkt_ack;
    logic [15:0] block_no;
    logic [9:0]  data_len;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        busy;
    logic        done;

    tftp_encode_controller #(.MAX_DATA(512), .LEN_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .pkt_ack(pkt_ack),
        .block_no(block_no), .data_len(data_len), .pay_data(pay_data),
        .pay_valid(pay_valid), .pay_ready(pay_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit [7:0] pay_q[$];
    bit [7:0] exp_q[$];
    bit       exp_last_q[$];
    bit [7:0] got_q[$];
    bit       got_last_q[$];
    int exp_n;
    int done_cnt, done_cycle, pay_hs, pay_ready_hi, stall_viol, post_busy;
    int busy_c1, first_valid_c, busy_at_done;

    // Reference model: the byte sequence a TFTP ACK/DATA packet must carry.
    task automatic model_packet(input bit ack, input logic [15:0] blk, input logic [9:0] dlen);
        exp_q.delete();
        exp_last_q.delete();
        exp_n = ack ? 0 : ((int'(dlen) > 512) ? 512 : int'(dlen));
        exp_q.push_back(8'h00);
        exp_q.push_back(ack ? 8'h04 : 8'h03);
        exp_q.push_back(blk[15:8]);
        exp_q.push_back(blk[7:0]);
        for (int i = 0; i < exp_n; i++) exp_q.push_back(pay_q[i]);
        for (int i = 0; i < exp_q.size(); i++) exp_last_q.push_back(i == exp_q.size() - 1);
    endtask

    function automatic int count_diffs();
        int d;
        int m;
        d = (got_q.size() > exp_q.size()) ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            if (got_q[i] != exp_q[i]) d++;
            if (got_last_q[i] != exp_last_q[i]) d++;
        end
        return d;
    endfunction

    // Drives one packet and records what the DUT produced.
    // rdy_pct < 0 toggles tx_ready every cycle. inject_at > 0 pulses a
    // competing start (block 0xBEEF) at that cycle after the real start.
    task automatic send_packet(input bit ack, input logic [15:0] blk, input logic [9:0] dlen,
                               input int rdy_pct, input int val_pct, input int inject_at,
                               input int max_cycles);
        int c;
        int pidx;
        bit prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        if (pay_q.size() == 0 && !ack)
            for (int i = 0; i < int'(dlen); i++) pay_q.push_back(8'($urandom));
        model_packet(ack, blk, dlen);
        got_q.delete();
        got_last_q.delete();
        done_cnt = 0; done_cycle = -1; pay_hs = 0; pay_ready_hi = 0; stall_viol = 0;
        post_busy = 0; busy_c1 = 0; first_valid_c = -1; busy_at_done = 0;
        pidx = 0; c = 0; prev_stall = 0; prev_data = 8'h00; prev_last = 1'b0;
        @(negedge clk);
        start = 1'b1; pkt_ack = ack; block_no = blk; data_len = dlen;
        tx_ready = 1'b0; pay_valid = 1'b0;
        while (c < max_cycles && (done_cycle < 0 || c < done_cycle + 2)) begin
            @(negedge clk);
            c++;
            if (c == inject_at) begin
                start = 1'b1; block_no = 16'hBEEF;
                pkt_ack = 1'($urandom); data_len = 10'($urandom_range(0, 20));
            end else begin
                start = 1'b0; block_no = 16'($urandom);
                pkt_ack = 1'($urandom); data_len = 10'($urandom);
            end
            if (rdy_pct < 0) tx_ready = c[0];
            else tx_ready = ($urandom_range(0, 99) < rdy_pct);
            pay_valid = ($urandom_range(0, 99) < val_pct);
            pay_data  = (pidx < pay_q.size()) ? pay_q[pidx] : 8'hEE;
            #1;
            if (c == 1) busy_c1 = busy;
            if (tx_valid && first_valid_c < 0) first_valid_c = c;
            if (prev_stall && tx_valid && (tx_data !== prev_data || tx_last !== prev_last))
                stall_viol++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                got_last_q.push_back(tx_last);
            end
            if (pay_ready) pay_ready_hi++;
            if (pay_valid && pay_ready) begin
                pay_hs++;
                pidx++;
            end
            if (done) begin
                done_cnt++;
                if (done_cycle < 0) done_cycle = c;
                if (busy) busy_at_done = 1;
            end
            if (done_cycle >= 0 && c > done_cycle && busy) post_busy++;
        end
        start = 1'b0; tx_ready = 1'b0; pay_valid = 1'b0;
        if (done_cycle < 0) $display("FAIL send_packet_timeout: no done within %0d cycles", max_cycles);
        pay_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pkt_ack = 1'b0; block_no = 16'h0; data_len = 10'd0;
        pay_data = 8'h5A; pay_valid = 1'b1; tx_ready = 1'b1;
        #3;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_last !== 1'b0) begin failures++; $display("FAIL reset_tx_last got=%b exp=0", tx_last); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (pay_ready !== 1'b0) begin failures++; $display("FAIL reset_pay_ready got=%b exp=0", pay_ready); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
        @(negedge clk); @(negedge clk);
        reset = 1'b0; pay_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack();
        send_packet(1'b1, 16'h0001, 10'd7, 100, 50, 0, 50);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL ack_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (done_cycle !== 5) begin failures++; $display("FAIL ack_done_cycle got=%0d exp=5", done_cycle); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ack_done_count got=%0d exp=1", done_cnt); end
        checks++; if (pay_ready_hi !== 0) begin failures++; $display("FAIL ack_pay_ready got=%0d exp=0", pay_ready_hi); end
        checks++; if (busy_c1 !== 1 || first_valid_c !== 1) begin failures++; $display("FAIL ack_latency busy=%0d first_valid=%0d exp=1,1", busy_c1, first_valid_c); end
        checks++; if (busy_at_done !== 0) begin failures++; $display("FAIL ack_busy_at_done got=%0d exp=0", busy_at_done); end
    endtask

    task automatic test_data_basic();
        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        send_packet(1'b0, 16'h1234, 10'd3, 100, 100, 0, 50);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL data3_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (pay_hs !== 3) begin failures++; $display("FAIL data3_pay_hs got=%0d exp=3", pay_hs); end
        checks++; if (done_cycle !== 8 || done_cnt !== 1) begin failures++; $display("FAIL data3_done got_cycle=%0d cnt=%0d exp=8,1", done_cycle, done_cnt); end
    endtask

    task automatic test_backpressure();
        send_packet(1'b0, 16'($urandom), 10'd4, -1, 60, 0, 200);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL bp_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (stall_viol !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_viol); end
        checks++; if (pay_hs !== 4 || done_cnt !== 1) begin failures++; $display("FAIL bp_counts got_hs=%0d done=%0d exp=4,1", pay_hs, done_cnt); end
    endtask

    task automatic test_boundaries();
        send_packet(1'b0, 16'hA55A, 10'd0, 100, 100, 0, 50);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL len0_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (pay_ready_hi !== 0 || done_cycle !== 5) begin failures++; $display("FAIL len0_timing got_pr=%0d done=%0d exp=0,5", pay_ready_hi, done_cycle); end
        send_packet(1'b0, 16'h0F0F, 10'd600, 100, 100, 0, 700);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL len600_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (pay_hs !== 512 || done_cycle !== 517) begin failures++; $display("FAIL len600_clamp got_hs=%0d done=%0d exp=512,517", pay_hs, done_cycle); end
        send_packet(1'b0, 16'h0102, 10'd1, 100, 100, 0, 50);
        checks++; if (count_diffs() !== 0 || done_cycle !== 6) begin failures++; $display("FAIL len1 diffs=%0d done=%0d exp=0,6", count_diffs(), done_cycle); end
    endtask

    task automatic test_reset_mid_packet();
        int dcnt;
        bit [7:0] p[$];
        for (int i = 0; i < 5; i++) p.push_back(8'($urandom_range(1, 255)));
        @(negedge clk);
        start = 1'b1; pkt_ack = 1'b0; block_no = 16'h4321; data_len = 10'd5;
        tx_ready = 1'b1; pay_valid = 1'b1; pay_data = 8'h00;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            pay_data = (c >= 5) ? p[c - 5] : 8'h00;
            #1;
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== p[1]) begin failures++; $display("FAIL rst_mid_byte2 got=%b/%h exp=1/%h", tx_valid, tx_data, p[1]); end
        #1 reset = 1'b1;
        #1;
        checks++; if ({tx_valid, tx_last, busy, done, pay_ready} !== 5'b0 || tx_data !== 8'h00) begin
            failures++; $display("FAIL rst_mid_outputs got=%b data=%h exp=00000 data=00", {tx_valid, tx_last, busy, done, pay_ready}, tx_data);
        end
        dcnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (done || tx_last) dcnt++;
        end
        reset = 1'b0; tx_ready = 1'b0; pay_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            if (done || tx_last || busy) dcnt++;
        end
        checks++; if (dcnt !== 0) begin failures++; $display("FAIL rst_mid_no_done got=%0d exp=0", dcnt); end
        send_packet(1'b0, 16'h7788, 10'd3, 100, 100, 0, 50);
        checks++; if (count_diffs() !== 0 || done_cnt !== 1) begin failures++; $display("FAIL rst_mid_recover diffs=%0d done=%0d exp=0,1", count_diffs(), done_cnt); end
    endtask

    task automatic test_start_ignored();
        send_packet(1'b0, 16'h1357, 10'd6, 100, 100, 3, 50);
        checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL busy_start_bytes got_n=%0d exp_n=%0d diffs=%0d", got_q.size(), exp_q.size(), count_diffs()); end
        checks++; if (done_cnt !== 1 || post_busy !== 0) begin failures++; $display("FAIL busy_start_done got=%0d post_busy=%0d exp=1,0", done_cnt, post_busy); end
        send_packet(1'b1, 16'h2468, 10'd0, 100, 100, 5, 50);
        checks++; if (count_diffs() !== 0 || post_busy !== 0) begin failures++; $display("FAIL done_start_ignored diffs=%0d post_busy=%0d exp=0,0", count_diffs(), post_busy); end
    endtask

    task automatic test_random();
        bit ack;
        logic [9:0] dlen;
        for (int k = 0; k < 8; k++) begin
            ack  = 1'($urandom);
            dlen = (k == 7) ? 10'd530 : 10'($urandom_range(0, 40));
            send_packet(ack, 16'($urandom), dlen, $urandom_range(30, 100), $urandom_range(30, 100), 0, 3000);
            checks++; if (count_diffs() !== 0) begin failures++; $display("FAIL rand%0d_bytes got_n=%0d exp_n=%0d diffs=%0d", k, got_q.size(), exp_q.size(), count_diffs()); end
            checks++; if (pay_hs !== exp_n || done_cnt !== 1 || stall_viol !== 0) begin
                failures++; $display("FAIL rand%0d_counts got_hs=%0d done=%0d stall=%0d exp=%0d,1,0", k, pay_hs, done_cnt, stall_viol, exp_n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data_basic();
        test_backpressure();
        test_boundaries();
        test_reset_mid_packet();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
